rv_trap_ctrl: RTL and testbench
===============================

// Module: rv_trap_ctrl
// PURPOSE
//  Trap/return sequencer directly downstream of rv_csr. Detects retiring EBREAK/ECALL/MRET,
//  pulses rv_csr to record the trap, waits for o_trap_pc/o_ret_addr to settle, then issues a
//  held PC-redirect handshake to fetch plus a one-cycle pipeline flush. Stalls upstream throughout.
// PARAMETERS
//  CSR_LATENCY  2  cycles from o_csr_ebreak high until i_trap_pc is valid (>=1)
// PORTS
//  i_clk              in   1   core clock, single clock domain
//  i_reset_n          in   1   asynchronous active-low reset
//  i_valid            in   1   instruction in this stage retires this cycle
//  i_ebreak           in   1   retiring instr is EBREAK
//  i_ecall            in   1   retiring instr is ECALL
//  i_mret             in   1   retiring instr is MRET
//  i_pc               in   32  PC of retiring instr
//  i_trap_pc          in   32  trap vector from rv_csr o_trap_pc
//  i_ret_addr         in   32  return address from rv_csr o_ret_addr
//  i_redirect_ready   in   1   fetch accepts redirect
//  o_csr_ebreak       out  1   one-cycle trap-record pulse to rv_csr i_ebreak
//  o_csr_pc           out  32  PC to record, to rv_csr i_pc
//  o_mcause           out  32  cause of current trap (3=EBREAK, 11=ECALL)
//  o_stall            out  1   hold upstream stages
//  o_redirect_valid   out  1   redirect request to fetch
//  o_redirect_pc      out  32  redirect target, word-aligned
//  o_flush            out  1   kill younger in-flight instrs
// BEHAVIOUR
//  - Reset: state IDLE, counter 0; all outputs 0 (o_csr_pc, o_mcause, o_redirect_pc = 32'h0).
//  - States: IDLE, CSR_UPD, WAIT, REDIRECT. Encoding one-hot not required.
//  - IDLE: event = i_valid & (i_ebreak|i_ecall|i_mret). Priority ebreak > ecall > mret if several set.
//    o_stall asserted combinationally in the event cycle, held until handshake completes.
//    ebreak/ecall: capture i_pc -> o_csr_pc, cause -> o_mcause; next state CSR_UPD.
//    mret: capture {i_ret_addr[31:2],2'b00} -> o_redirect_pc; next state REDIRECT.
//  - CSR_UPD: o_csr_ebreak=1 exactly one cycle; counter loaded CSR_LATENCY; -> WAIT.
//  - WAIT: counter decrements each cycle; at counter==1 capture {i_trap_pc[31:2],2'b00}
//    -> o_redirect_pc; -> REDIRECT. Total event-to-redirect_valid for ebreak = CSR_LATENCY+2 cycles.
//  - REDIRECT: o_redirect_valid=1, o_redirect_pc stable while valid & !ready.
//    On valid&ready: o_flush=1 that same cycle, -> IDLE; o_stall drops next cycle.
//  - Events arriving outside IDLE are ignored (upstream is stalled; no queuing).
//  - i_valid=0 with type bits set: no event.
//  - Counter width $clog2(CSR_LATENCY+1); no wrap possible, reloaded every CSR_UPD.
//  - Async reset mid-sequence: immediate return to IDLE, pending redirect dropped, no flush.
//  - o_mcause holds last cause until next trap; not changed by mret.
// CONFIGURATION
//  - Macro TRAP_ECALL_EN. Defined: ECALL is a trap event, cause 11, path as EBREAK.
//    Undefined: i_ecall ignored entirely (retires as NOP, no stall); port kept, unused.
// STRUCTURE
//  - rv_structs.vh: trap_state_t enum (IDLE/CSR_UPD/WAIT/REDIRECT).
//  - rv_defines.vh: TRAP_CAUSE_EBREAK=32'd3, TRAP_CAUSE_ECALL_M=32'd11.
//  - No sub-module; FSM, latency counter and capture regs inline.
// TESTING
//  - Reset: assert i_reset_n=0 mid-WAIT -> all outputs 0, IDLE; no o_flush after release.
//  - EBREAK pc=0x100, trap_pc=0x200, CSR_LATENCY=2, ready=1 -> csr_ebreak pulse cycle+1, csr_pc=0x100,
//    mcause=3, redirect_valid at cycle+4 with pc 0x200, flush same cycle.
//  - Backpressure: ready=0 for 5 cycles in REDIRECT -> valid/pc held, stall high, flush only on accept.
//  - MRET ret_addr=0x1236 -> redirect_pc=0x1234 next cycle, no csr_ebreak, mcause unchanged.
//  - Simultaneous ebreak+mret -> ebreak path taken; second EBREAK during WAIT -> ignored.
//  - ECALL pc=0x40 -> with TRAP_ECALL_EN mcause=11 and redirect; without, no stall, no redirect.

Source files
------------

// File: rtl/rv_trap_ctrl_pkg.sv
// Shared types and constants for the trap/return sequencer.
package rv_trap_ctrl_pkg;

    // Sequencer states
    typedef enum logic [1:0] {
        StIdle,
        StCsrUpd,
        StWait,
        StRedirect
    } trap_state_t;

    // Machine-mode trap causes reported on o_mcause
    localparam logic [31:0] TrapCauseEbreak = 32'd3;
    localparam logic [31:0] TrapCauseEcallM = 32'd11;

    // Redirect targets are always word-aligned
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/rv_trap_ctrl.sv
// Trap/return sequencer sitting after rv_csr.
// EBREAK (and ECALL when TRAP_ECALL_EN is defined) pulse rv_csr, wait CSR_LATENCY cycles
// for the trap vector, then redirect fetch. MRET redirects straight to the return address.
// Upstream is stalled from the event cycle until the redirect handshake completes.
module rv_trap_ctrl
    import rv_trap_ctrl_pkg::*;
#(
    parameter int unsigned CSR_LATENCY = 2
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_valid,
    input  logic        i_ebreak,
    input  logic        i_ecall,
    input  logic        i_mret,
    input  logic [31:0] i_pc,
    input  logic [31:0] i_trap_pc,
    input  logic [31:0] i_ret_addr,
    input  logic        i_redirect_ready,
    output logic        o_csr_ebreak,
    output logic [31:0] o_csr_pc,
    output logic [31:0] o_mcause,
    output logic        o_stall,
    output logic        o_redirect_valid,
    output logic [31:0] o_redirect_pc,
    output logic        o_flush
);

    localparam int unsigned CntW = $clog2(CSR_LATENCY + 1);

    trap_state_t       state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [31:0]       csr_pc_q, csr_pc_d;
    logic [31:0]       mcause_q, mcause_d;
    logic [31:0]       redirect_pc_q, redirect_pc_d;

    logic              ecall_hit;
    logic              trap_hit;
    logic              ret_hit;

`ifdef TRAP_ECALL_EN
    assign ecall_hit = i_ecall;
`else
    // ECALL retires as a plain instruction in this build
    assign ecall_hit = 1'b0;
    logic unused_ecall;
    assign unused_ecall = i_ecall;
`endif

    // Low address bits are dropped by word alignment
    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^{i_trap_pc[1:0], i_ret_addr[1:0]};

    assign trap_hit = i_valid & (i_ebreak | ecall_hit);
    assign ret_hit  = i_valid & i_mret;

    // Next-state, capture and output decode
    always_comb begin
        state_d          = state_q;
        cnt_d            = cnt_q;
        csr_pc_d         = csr_pc_q;
        mcause_d         = mcause_q;
        redirect_pc_d    = redirect_pc_q;
        o_stall          = 1'b0;
        o_csr_ebreak     = 1'b0;
        o_redirect_valid = 1'b0;
        o_flush          = 1'b0;

        case (state_q)
            StIdle: begin
                // Traps win over MRET when both are flagged
                if (trap_hit) begin
                    o_stall  = 1'b1;
                    csr_pc_d = i_pc;
                    mcause_d = i_ebreak ? TrapCauseEbreak : TrapCauseEcallM;
                    state_d  = StCsrUpd;
                end else if (ret_hit) begin
                    o_stall       = 1'b1;
                    redirect_pc_d = word_align(i_ret_addr);
                    state_d       = StRedirect;
                end
            end
            StCsrUpd: begin
                o_stall      = 1'b1;
                o_csr_ebreak = 1'b1;
                cnt_d        = CntW'(CSR_LATENCY);
                state_d      = StWait;
            end
            StWait: begin
                o_stall = 1'b1;
                cnt_d   = cnt_q - CntW'(1);
                // i_trap_pc becomes valid in the cycle the count reaches one
                if (cnt_q == CntW'(1)) begin
                    redirect_pc_d = word_align(i_trap_pc);
                    state_d       = StRedirect;
                end
            end
            StRedirect: begin
                o_stall          = 1'b1;
                o_redirect_valid = 1'b1;
                if (i_redirect_ready) begin
                    o_flush = 1'b1;
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State, latency counter and capture registers
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q       <= StIdle;
            cnt_q         <= '0;
            csr_pc_q      <= 32'h0;
            mcause_q      <= 32'h0;
            redirect_pc_q <= 32'h0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            csr_pc_q      <= csr_pc_d;
            mcause_q      <= mcause_d;
            redirect_pc_q <= redirect_pc_d;
        end
    end

    assign o_csr_pc      = csr_pc_q;
    assign o_mcause      = mcause_q;
    assign o_redirect_pc = redirect_pc_q;

endmodule

// File: tb/tb_rv_trap_ctrl.sv
// Self-checking bench for rv_trap_ctrl: vector table replayed through a per-cycle
// expected-output queue, plus a hand-written mid-sequence reset case.
module tb_rv_trap_ctrl;

    localparam int unsigned Lat = 2;
    localparam logic [31:0] Junk = 32'hDEAD_BEE0;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid, ebreak, ecall, mret, ready;
    logic [31:0] pc, trap_pc, ret_addr;
    logic        csr_ebreak, stall, rvalid, flush;
    logic [31:0] csr_pc, mcause, rpc;

    always #5 clk = ~clk;

    rv_trap_ctrl #(.CSR_LATENCY(Lat)) dut (
        .i_clk            (clk),
        .i_reset_n        (rst_n),
        .i_valid          (valid),
        .i_ebreak         (ebreak),
        .i_ecall          (ecall),
        .i_mret           (mret),
        .i_pc             (pc),
        .i_trap_pc        (trap_pc),
        .i_ret_addr       (ret_addr),
        .i_redirect_ready (ready),
        .o_csr_ebreak     (csr_ebreak),
        .o_csr_pc         (csr_pc),
        .o_mcause         (mcause),
        .o_stall          (stall),
        .o_redirect_valid (rvalid),
        .o_redirect_pc    (rpc),
        .o_flush          (flush)
    );

    typedef struct packed {
        logic        stall;
        logic        csr_ebreak;
        logic        rvalid;
        logic        flush;
        logic [31:0] csr_pc;
        logic [31:0] mcause;
        logic [31:0] rpc;
    } obs_t;

    // kind: 0 = no event, 1 = trap, 2 = return
    typedef struct {
        string       name;
        logic        valid, eb, ec, mr;
        logic [31:0] pc, trap_pc, ret_addr;
        int          wait_n;
        bit          noise;
        int          kind;
        logic [31:0] exp_pc;
        logic [31:0] cause;
    } vec_t;

    vec_t        vecs[8];
    obs_t        exp_q[$];
    int          total = 0;
    int          bad = 0;
    logic [31:0] m_csr_pc = 32'h0;
    logic [31:0] m_mcause = 32'h0;

    task automatic drive_idle();
        valid = 1'b0; ebreak = 1'b0; ecall = 1'b0; mret = 1'b0;
        pc = 32'h0; trap_pc = Junk; ret_addr = 32'h0; ready = 1'b0;
    endtask

    // Sample at the falling edge and compare with the oldest expectation
    task automatic check_cycle(input string name, input int c, input bit mask_rpc);
        obs_t e, g;
        @(negedge clk);
        e = exp_q.pop_front();
        g = '{stall: stall, csr_ebreak: csr_ebreak, rvalid: rvalid, flush: flush,
              csr_pc: csr_pc, mcause: mcause, rpc: mask_rpc ? rpc : 32'h0};
        total++;
        if (g !== e) begin
            bad++;
            $display("FAIL %s c=%0d got stall=%b ebk=%b rv=%b fl=%b cpc=%h mc=%h rpc=%h exp stall=%b ebk=%b rv=%b fl=%b cpc=%h mc=%h rpc=%h",
                     name, c, g.stall, g.csr_ebreak, g.rvalid, g.flush, g.csr_pc, g.mcause, g.rpc,
                     e.stall, e.csr_ebreak, e.rvalid, e.flush, e.csr_pc, e.mcause, e.rpc);
        end
    endtask

    task automatic run_vec(input vec_t v);
        int   start, len;
        obs_t e;
        start = (v.kind == 1) ? int'(Lat) + 2 : 1;
        len   = (v.kind == 0) ? 1 : start + v.wait_n + 1;
        for (int c = 0; c <= len; c++) begin
            drive_idle();
            if (c == 0) begin
                valid = v.valid; ebreak = v.eb; ecall = v.ec; mret = v.mr; pc = v.pc;
            end else if (v.noise && c < len) begin
                valid = 1'b1; ebreak = 1'b1; pc = 32'h999;
            end
            ret_addr = v.ret_addr;
            if (v.kind == 1 && c >= 1 + int'(Lat)) trap_pc = v.trap_pc;
            ready = (v.kind != 0) && (c == start + v.wait_n);
            if (v.kind == 1 && c == 1) begin
                m_csr_pc = v.pc;
                m_mcause = v.cause;
            end
            e.stall      = (v.kind != 0) && (c < len);
            e.csr_ebreak = (v.kind == 1) && (c == 1);
            e.rvalid     = (v.kind != 0) && (c >= start) && (c < len);
            e.flush      = (v.kind != 0) && (c == len - 1);
            e.csr_pc     = m_csr_pc;
            e.mcause     = m_mcause;
            e.rpc        = e.rvalid ? v.exp_pc : 32'h0;
            exp_q.push_back(e);
            check_cycle(v.name, c, e.rvalid);
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        vec_t v;
        obs_t z;
        drive_idle();
        z = '0;

        vecs[0] = '{"ebreak", 1, 1, 0, 0, 32'h100, 32'h200, 32'h0, 0, 0, 1, 32'h200, 32'd3};
        vecs[1] = '{"ebreak_bp", 1, 1, 0, 0, 32'h104, 32'h307, 32'h0, 5, 0, 1, 32'h304, 32'd3};
        vecs[2] = '{"mret", 1, 0, 0, 1, 32'h0, 32'h0, 32'h1236, 0, 0, 2, 32'h1234, 32'd0};
        vecs[3] = '{"ebreak_mret", 1, 1, 0, 1, 32'h180, 32'h400, 32'h998, 1, 1, 1, 32'h400, 32'd3};
        vecs[4] = '{"no_valid", 0, 1, 0, 1, 32'h500, 32'h600, 32'h700, 0, 0, 0, 32'h0, 32'd0};
        vecs[5] = '{"mret_bp", 1, 0, 0, 1, 32'h0, 32'h0, 32'hFFFF_FFFF, 3, 1, 2, 32'hFFFF_FFFC, 32'd0};
`ifdef TRAP_ECALL_EN
        vecs[6] = '{"ecall", 1, 0, 1, 0, 32'h40, 32'h80, 32'h0, 0, 0, 1, 32'h80, 32'd11};
        vecs[7] = '{"ecall_mret", 1, 0, 1, 1, 32'h44, 32'h8C, 32'h2000, 2, 0, 1, 32'h8C, 32'd11};
`else
        vecs[6] = '{"ecall", 1, 0, 1, 0, 32'h40, 32'h80, 32'h0, 0, 0, 0, 32'h0, 32'd0};
        vecs[7] = '{"ecall_mret", 1, 0, 1, 1, 32'h44, 32'h8C, 32'h2000, 2, 0, 2, 32'h2000, 32'd0};
`endif

        // Reset state
        repeat (3) @(posedge clk);
        exp_q.push_back(z);
        check_cycle("reset_state", 0, 1'b1);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;

        foreach (vecs[i]) begin
            v = vecs[i];
            run_vec(v);
        end

        // Reset asserted while waiting on the CSR latency
        valid = 1'b1; ebreak = 1'b1; pc = 32'h500;
        @(posedge clk);
        #1 drive_idle();
        @(posedge clk);
        #1 drive_idle();
        #2 rst_n = 1'b0;
        #1;
        m_csr_pc = 32'h0;
        m_mcause = 32'h0;
        total++;
        if ({stall, csr_ebreak, rvalid, flush, csr_pc, mcause, rpc} !== '0) begin
            bad++;
            $display("FAIL reset_mid got stall=%b ebk=%b rv=%b fl=%b cpc=%h mc=%h rpc=%h exp all zero",
                     stall, csr_ebreak, rvalid, flush, csr_pc, mcause, rpc);
        end
        #2 rst_n = 1'b1;
        ready = 1'b1;
        trap_pc = 32'h600;
        for (int c = 0; c < 6; c++) begin
            exp_q.push_back(z);
            check_cycle("post_reset_quiet", c, 1'b1);
            @(posedge clk);
            #1;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
